// File: rtl/ssp_motorola_slave.sv
// Motorola-format SSP slave: oversampled serial pins, one-word TX holding register, valid/ready RX.
// Optional build macro SSP_SLV_ECHO_EN: an empty-holding-register load transmits the last received word.
//
// state  | meaning
// IDLE   | frame select high; pad driver off, waiting for SSPFSSIN to fall
// ACTIVE | inside a frame; shifting on sampling edges, driving SSPTXD
module ssp_motorola_slave #(
   parameter int DATA_W = 8,
   parameter bit SPO    = 1'b0,
   parameter bit SPH    = 1'b0
) (
   input  logic              SSPCLK,
   input  logic              nSSPRST,
   input  logic              SSPCLKIN,
   input  logic              SSPFSSIN,
   input  logic              SSPRXD,
   output logic              SSPTXD,
   output logic              nSSPOE,
   input  logic [DATA_W-1:0] TX_DATA,
   input  logic              TX_VALID,
   output logic              TX_READY,
   output logic [DATA_W-1:0] RX_DATA,
   output logic              RX_VALID,
   input  logic              RX_READY,
   output logic              TX_UNDR,
   output logic              RX_OVR,
   output logic              FRAME_ERR
);

   localparam int CW = $clog2(DATA_W + 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t            state;
   logic [1:0]        clk_sync, fss_sync, rxd_sync;
   logic              clk_d, fss_d;
   logic [DATA_W-1:0] shreg;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] hold;
   logic              hold_full;
   logic              drive_pend;

   logic              clk_rise, clk_fall, lead, trail, samp, drv;
   logic              fss_fall, fss_rise;
   logic              active, start, word_done, load, wr;
   logic [DATA_W-1:0] shifted, empty_val, load_val;

   assign clk_rise  = clk_sync[1] & ~clk_d;
   assign clk_fall  = ~clk_sync[1] & clk_d;
   assign lead      = SPO ? clk_fall : clk_rise;
   assign trail     = SPO ? clk_rise : clk_fall;
   assign samp      = SPH ? trail : lead;
   assign drv       = SPH ? lead : trail;
   assign fss_fall  = ~fss_sync[1] & fss_d;
   assign fss_rise  = fss_sync[1] & ~fss_d;

   assign active    = (state == ACTIVE);
   assign start     = !active && fss_fall;
   assign word_done = active && !fss_rise && samp && (cnt == CW'(DATA_W - 1));
   assign load      = start || word_done;
   assign shifted   = {shreg[DATA_W-2:0], rxd_sync[1]};
   assign wr        = TX_VALID && !hold_full;
   assign TX_READY  = !hold_full;

`ifdef SSP_SLV_ECHO_EN
   logic [DATA_W-1:0] last_rx;

   // The word completing this cycle is the freshest candidate for an echo reload.
   assign empty_val = word_done ? shifted : last_rx;

   always_ff @(posedge SSPCLK) begin
      if (!nSSPRST)
         last_rx <= '0;
      else if (word_done)
         last_rx <= shifted;
   end
`else
   assign empty_val = '0;
`endif

   assign load_val = hold_full ? hold : empty_val;

   always_ff @(posedge SSPCLK) begin
      if (!nSSPRST) begin
         clk_sync <= {SPO, SPO};
         fss_sync <= 2'b11;
         rxd_sync <= 2'b00;
         clk_d    <= SPO;
         fss_d    <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[0], SSPCLKIN};
         fss_sync <= {fss_sync[0], SSPFSSIN};
         rxd_sync <= {rxd_sync[0], SSPRXD};
         clk_d    <= clk_sync[1];
         fss_d    <= fss_sync[1];
      end
   end

   always_ff @(posedge SSPCLK) begin
      if (!nSSPRST) begin
         state      <= IDLE;
         shreg      <= '0;
         cnt        <= '0;
         hold       <= '0;
         hold_full  <= 1'b0;
         drive_pend <= 1'b0;
         SSPTXD     <= 1'b0;
         nSSPOE     <= 1'b1;
         RX_DATA    <= '0;
         RX_VALID   <= 1'b0;
         TX_UNDR    <= 1'b0;
         RX_OVR     <= 1'b0;
         FRAME_ERR  <= 1'b0;
      end else begin
         TX_UNDR   <= load && !hold_full;
         RX_OVR    <= 1'b0;
         FRAME_ERR <= 1'b0;

         // SPH=0 presents the MSB as soon as the frame opens; later bits follow the drive edge.
         drive_pend <= (start && !SPH) || (active && !fss_rise && drv);
         if (drive_pend)
            SSPTXD <= shreg[DATA_W-1];

         // A same-cycle load sees the old content; the incoming word stays held.
         hold_full <= (hold_full && !load) || wr;
         if (wr)
            hold <= TX_DATA;

         if (RX_VALID && RX_READY)
            RX_VALID <= 1'b0;

         case (state)
            IDLE: begin
               if (fss_fall) begin
                  state  <= ACTIVE;
                  nSSPOE <= 1'b0;
                  shreg  <= load_val;
                  cnt    <= '0;
               end
            end
            ACTIVE: begin
               if (fss_rise) begin
                  state     <= IDLE;
                  nSSPOE    <= 1'b1;
                  cnt       <= '0;
                  FRAME_ERR <= (cnt != '0);
               end else if (word_done) begin
                  shreg <= load_val;
                  cnt   <= '0;
                  if (RX_VALID && !RX_READY) begin
                     RX_OVR <= 1'b1;
                  end else begin
                     RX_DATA  <= shifted;
                     RX_VALID <= 1'b1;
                  end
               end else if (samp) begin
                  shreg <= shifted;
                  cnt   <= cnt + CW'(1);
               end
            end
            default: begin
               state  <= IDLE;
               nSSPOE <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ssp_motorola_slave.sv
// Directed bench: an 8-bit mode-0 slave and a 16-bit mode-3 slave driven by behavioural masters,
// with RX words checked against a scoreboard queue.
module tb_ssp_motorola_slave;

   logic clk = 1'b0;
   logic nrst = 1'b0;

   logic        a_sclk = 1'b0, a_fss = 1'b1, a_rxd = 1'b0;
   logic        a_txd, a_oe;
   logic [7:0]  a_txdata = '0;
   logic        a_txv = 1'b0, a_tx_ready;
   logic [7:0]  a_rx_data;
   logic        a_rx_valid, a_rx_ready = 1'b1;
   logic        a_undr, a_ovr, a_fe;

   logic        b_sclk = 1'b1, b_fss = 1'b1, b_rxd = 1'b0;
   logic        b_txd, b_oe;
   logic [15:0] b_txdata = '0;
   logic        b_txv = 1'b0, b_tx_ready;
   logic [15:0] b_rx_data;
   logic        b_rx_valid, b_rx_ready = 1'b1;
   logic        b_undr, b_ovr, b_fe;

   int total = 0;
   int bad = 0;
   int na_undr = 0, na_ovr = 0, na_fe = 0, nb_undr = 0;
   logic [15:0] qa[$];
   logic [15:0] qb[$];

   ssp_motorola_slave #(.DATA_W(8), .SPO(1'b0), .SPH(1'b0)) dut_a (
      .SSPCLK(clk), .nSSPRST(nrst), .SSPCLKIN(a_sclk), .SSPFSSIN(a_fss), .SSPRXD(a_rxd),
      .SSPTXD(a_txd), .nSSPOE(a_oe), .TX_DATA(a_txdata), .TX_VALID(a_txv), .TX_READY(a_tx_ready),
      .RX_DATA(a_rx_data), .RX_VALID(a_rx_valid), .RX_READY(a_rx_ready),
      .TX_UNDR(a_undr), .RX_OVR(a_ovr), .FRAME_ERR(a_fe)
   );

   ssp_motorola_slave #(.DATA_W(16), .SPO(1'b1), .SPH(1'b1)) dut_b (
      .SSPCLK(clk), .nSSPRST(nrst), .SSPCLKIN(b_sclk), .SSPFSSIN(b_fss), .SSPRXD(b_rxd),
      .SSPTXD(b_txd), .nSSPOE(b_oe), .TX_DATA(b_txdata), .TX_VALID(b_txv), .TX_READY(b_tx_ready),
      .RX_DATA(b_rx_data), .RX_VALID(b_rx_valid), .RX_READY(b_rx_ready),
      .TX_UNDR(b_undr), .RX_OVR(b_ovr), .FRAME_ERR(b_fe)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (a_undr) na_undr++;
      if (a_ovr)  na_ovr++;
      if (a_fe)   na_fe++;
      if (b_undr) nb_undr++;
   end

   always @(negedge clk) begin
      if (a_rx_valid && a_rx_ready) begin
         if (qa.size() == 0) begin
            total++;
            bad++;
            $error("FAIL rx_a_unexpected observed=%h expected=none", a_rx_data);
         end else begin
            chk("rx_a_word", {24'h0, a_rx_data}, {16'h0, qa.pop_front()});
         end
      end
      if (b_rx_valid && b_rx_ready) begin
         if (qb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL rx_b_unexpected observed=%h expected=none", b_rx_data);
         end else begin
            chk("rx_b_word", {16'h0, b_rx_data}, {16'h0, qb.pop_front()});
         end
      end
   end

   task automatic tx_write_a(input logic [7:0] d);
      int n = 0;
      a_txdata = d;
      a_txv = 1'b1;
      while (!a_tx_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("tx_a_write_timeout", (n >= 3000), 0);
      @(negedge clk);
      a_txv = 1'b0;
   endtask

   task automatic tx_write_b(input logic [15:0] d);
      int n = 0;
      b_txdata = d;
      b_txv = 1'b1;
      while (!b_tx_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("tx_b_write_timeout", (n >= 3000), 0);
      @(negedge clk);
      b_txv = 1'b0;
   endtask

   // Mode-0 master: idle-low clock, sample on rising, change on falling.
   task automatic m0(input int nbits, input logic [15:0] mosi, output logic [15:0] miso);
      miso = '0;
      a_fss = 1'b0;
      cyc(8);
      for (int i = 0; i < nbits; i++) begin
         a_rxd = mosi[nbits-1-i];
         cyc(8);
         a_sclk = 1'b1;
         miso = {miso[14:0], a_txd};
         chk("oe_a_in_frame", a_oe, 0);
         cyc(8);
         a_sclk = 1'b0;
      end
      cyc(8);
      a_fss = 1'b1;
      cyc(4);
   endtask

   // Mode-3 master: idle-high clock, change on falling, sample on rising.
   task automatic m3(input int nbits, input logic [31:0] mosi, output logic [31:0] miso);
      miso = '0;
      b_fss = 1'b0;
      cyc(8);
      for (int i = 0; i < nbits; i++) begin
         b_sclk = 1'b0;
         b_rxd = mosi[nbits-1-i];
         cyc(8);
         b_sclk = 1'b1;
         miso = {miso[30:0], b_txd};
         chk("oe_b_in_frame", b_oe, 0);
         cyc(8);
      end
      cyc(4);
      b_fss = 1'b1;
      cyc(8);
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_txd"}, a_txd, 0);
      chk({tag, "_oe"}, a_oe, 1);
      chk({tag, "_tx_ready"}, a_tx_ready, 1);
      chk({tag, "_rx_valid"}, a_rx_valid, 0);
      chk({tag, "_rx_data"}, a_rx_data, 0);
      chk({tag, "_pulses"}, {a_undr, a_ovr, a_fe}, 0);
   endtask

   initial begin
      logic [15:0] w;
      logic [31:0] wb;
      logic [7:0]  exp3;
      int s_undr, s_ovr, s_fe;

      nrst = 1'b0;
      cyc(3);
      chk_reset_a("reset");
      chk("reset_b_oe", b_oe, 1);
      nrst = 1'b1;
      cyc(4);

      // mode 0 basic word
      tx_write_a(8'h3C);
      qa.push_back(16'h00A5);
      m0(8, 16'h00A5, w);
      chk("t1_miso", w[7:0], 8'h3C);
      chk("t1_oe_after", a_oe, 1);
      cyc(4);
      chk("t1_rxq_empty", qa.size(), 0);

      // empty holding register at frame start
`ifdef SSP_SLV_ECHO_EN
      exp3 = 8'hA5;
`else
      exp3 = 8'h00;
`endif
      s_undr = na_undr;
      qa.push_back(16'h005A);
      fork
         m0(8, 16'h005A, w);
         begin
            cyc(40);
            tx_write_a(8'h77);
         end
      join
      chk("t3_miso", w[7:0], exp3);
      chk("t3_undr_count", na_undr - s_undr, 1);
      cyc(4);
      chk("t3_rxq_empty", qa.size(), 0);

      // overrun with consumer stalled across two words
      a_rx_ready = 1'b0;
      s_ovr = na_ovr;
      m0(16, 16'h1122, w);
      cyc(4);
      chk("t4_rx_data", a_rx_data, 8'h11);
      chk("t4_rx_valid", a_rx_valid, 1);
      chk("t4_ovr_count", na_ovr - s_ovr, 1);
      qa.push_back(16'h0011);
      a_rx_ready = 1'b1;
      cyc(4);
      chk("t4_rxq_empty", qa.size(), 0);
      chk("t4_rx_valid_cleared", a_rx_valid, 0);

      // frame select released after 5 bits
      s_fe = na_fe;
      m0(5, 16'h0016, w);
      chk("t5_oe_4cyc", a_oe, 1);
      chk("t5_fe_count", na_fe - s_fe, 1);
      chk("t5_no_rx_valid", a_rx_valid, 0);
      cyc(4);
      tx_write_a(8'h96);
      qa.push_back(16'h0081);
      m0(8, 16'h0081, w);
      chk("t5_next_miso", w[7:0], 8'h96);
      chk("t5_fe_count_after", na_fe - s_fe, 1);
      cyc(4);
      chk("t5_rxq_empty", qa.size(), 0);

      // reset in the middle of a word
      tx_write_a(8'h55);
      a_fss = 1'b0;
      cyc(8);
      a_rxd = 1'b1;
      cyc(8);
      a_sclk = 1'b1;
      cyc(8);
      a_sclk = 1'b0;
      cyc(8);
      a_sclk = 1'b1;
      cyc(4);
      chk("t6_oe_before_reset", a_oe, 0);
      s_undr = na_undr;
      s_ovr = na_ovr;
      s_fe = na_fe;
      nrst = 1'b0;
      cyc(1);
      chk_reset_a("t6_reset");
      a_sclk = 1'b0;
      a_fss = 1'b1;
      cyc(4);
      nrst = 1'b1;
      cyc(8);
      chk("t6_no_pulses", {na_undr - s_undr, na_ovr - s_ovr, na_fe - s_fe}, 0);
      chk("t6_rx_valid", a_rx_valid, 0);
      tx_write_a(8'h3C);
      qa.push_back(16'h00A5);
      m0(8, 16'h00A5, w);
      chk("t6_miso", w[7:0], 8'h3C);
      cyc(4);
      chk("t6_rxq_empty", qa.size(), 0);

      // 16-bit mode 3 continuous frame of two words
      tx_write_b(16'hCAFE);
      qb.push_back(16'h1234);
      qb.push_back(16'hBEEF);
      fork
         m3(32, 32'h1234BEEF, wb);
         begin
            tx_write_b(16'h0F0F);
            tx_write_b(16'h5555);
         end
      join
      chk("t2_miso", wb, 32'hCAFE0F0F);
      chk("t2_undr_count", nb_undr, 0);
      chk("t2_oe_after", b_oe, 1);
      cyc(4);
      chk("t2_rxq_empty", qb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
